// File: rtl/sum_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : sum_bcd_display
// Purpose  : Serial double-dabble binary-to-BCD converter with registered,
//            active-low 7-segment outputs and optional leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module sum_bcd_display #(
  parameter int p_WIDTH  = 9,
  parameter int p_DIGITS = 4
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst,
  input  logic [p_WIDTH-1:0]      iwv_value,
  input  logic                    iw_start,
  input  logic                    iw_blank,
  output logic                    ow_busy,
  output logic                    ow_done,
  output logic [4*p_DIGITS-1:0]   owv_bcd,
  output logic [7*p_DIGITS-1:0]   owv_hex
);

  localparam int c_BW = 4 * p_DIGITS;
  localparam int c_HW = 7 * p_DIGITS;
  localparam int c_CW = (p_WIDTH > 1) ? $clog2(p_WIDTH) : 1;
  localparam logic [63:0] c_LIMIT = 64'(10 ** p_DIGITS);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(p_WIDTH - 1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SHIFT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [p_WIDTH-1:0] bin_q;
  logic [c_BW-1:0]    bcd_q;
  logic [c_CW-1:0]    cnt_q;
  logic               blank_q;
  logic               ovf_q;
  logic               done_q;
  logic [c_BW-1:0]    bcd_out_q;
  logic [c_HW-1:0]    hex_out_q;

  logic               w_accept;
  logic               w_last;
  logic [c_BW-1:0]    w_adj;
  logic [c_BW-1:0]    w_shift_bcd;
  logic [c_HW-1:0]    w_seg;
  logic [c_HW-1:0]    w_hex;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign w_accept    = (state_q == c_IDLE) && iw_start;
  assign w_last      = (state_q == c_SHIFT) && (cnt_q == c_LAST);
  assign w_shift_bcd = {w_adj[c_BW-2:0], bin_q[p_WIDTH-1]};

  genvar g;
  generate
    for (g = 0; g < p_DIGITS; g++) begin : g_digit
      assign w_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? (bcd_q[4*g +: 4] + 4'd3)
                                                         : bcd_q[4*g +: 4];
      assign w_seg[7*g +: 7] = seg7(w_shift_bcd[4*g +: 4]);
    end
  endgenerate

  // Blank digits from the top down until the first nonzero one; digit 0 always shows.
  always_comb begin
    logic v_run;
    w_hex = w_seg;
    v_run = blank_q;
    for (int i = p_DIGITS - 1; i >= 1; i--) begin
      if (w_shift_bcd[4*i +: 4] != 4'd0) v_run = 1'b0;
      if (v_run) w_hex[7*i +: 7] = 7'h7F;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (iw_start) state_d = c_SHIFT;
      c_SHIFT: if (w_last)   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    ow_busy = (state_q == c_SHIFT);
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      hex_out_q <= '1;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        bin_q   <= iwv_value;
        blank_q <= iw_blank;
        bcd_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= (64'(iwv_value) >= c_LIMIT);
      end else if (state_q == c_SHIFT) begin
        bin_q <= bin_q << 1;
        bcd_q <= w_shift_bcd;
        cnt_q <= cnt_q + 1'b1;
        if (w_last) begin
          done_q <= 1'b1;
          if (ovf_q) begin
            bcd_out_q <= '1;
            hex_out_q <= {p_DIGITS{7'h3F}};
          end else begin
            bcd_out_q <= w_shift_bcd;
            hex_out_q <= w_hex;
          end
        end
      end
    end
  end

  assign ow_done = done_q;
  assign owv_bcd = bcd_out_q;
  assign owv_hex = hex_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_bcd_display.sv
`default_nettype none
// Testbench for sum_bcd_display: directed vectors, queue scoreboard with
// per-instance monitors for the default (9-bit) and a 14-bit configuration.
module tb_sum_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  val9   = '0;
  logic        start9 = 1'b0, blank9 = 1'b0;
  logic        busy9, done9;
  logic [15:0] bcd9;
  logic [27:0] hex9;
  logic [13:0] val14   = '0;
  logic        start14 = 1'b0, blank14 = 1'b0;
  logic        busy14, done14;
  logic [15:0] bcd14;
  logic [27:0] hex14;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [43:0] q9[$];
  logic [43:0] q14[$];

  int  busy_cnt9 = 0, busy_cnt14 = 0;
  bit  per_chk = 1'b0;
  int  last_done = -1;
  bit  prev_done9 = 1'b0;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  sum_bcd_display #(.p_WIDTH(9), .p_DIGITS(4)) u_dut9 (
    .iw_clk(clk), .iw_rst(rst), .iwv_value(val9), .iw_start(start9),
    .iw_blank(blank9), .ow_busy(busy9), .ow_done(done9),
    .owv_bcd(bcd9), .owv_hex(hex9));

  sum_bcd_display #(.p_WIDTH(14), .p_DIGITS(4)) u_dut14 (
    .iw_clk(clk), .iw_rst(rst), .iwv_value(val14), .iw_start(start14),
    .iw_blank(blank14), .ow_busy(busy14), .ow_done(done14),
    .owv_bcd(bcd14), .owv_hex(hex14));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor for the 9-bit instance
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt9  = 0;
      prev_done9 = 1'b0;
    end else begin
      if (busy9) busy_cnt9++;
      if (done9 && prev_done9) chk("done9_width", 64'd2, 64'd1);
      if (done9) begin
        logic [43:0] e;
        chk("busy9_cycles", 64'(busy_cnt9), 64'd9);
        chk("busy9_low_at_done", 64'(busy9), 64'd0);
        if (per_chk && last_done >= 0) chk("done9_period", 64'(cyc - last_done), 64'd10);
        last_done = cyc;
        busy_cnt9 = 0;
        if (q9.size() == 0) begin
          chk("done9_unexpected", 64'(bcd9), 64'hDEAD);
        end else begin
          e = q9.pop_front();
          chk("bcd9", 64'(bcd9), 64'(e[43:28]));
          chk("hex9", 64'(hex9), 64'(e[27:0]));
        end
      end
      prev_done9 = done9;
    end
  end

  // Monitor for the 14-bit instance
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt14 = 0;
    end else begin
      if (busy14) busy_cnt14++;
      if (done14) begin
        logic [43:0] e;
        chk("busy14_cycles", 64'(busy_cnt14), 64'd14);
        busy_cnt14 = 0;
        if (q14.size() == 0) begin
          chk("done14_unexpected", 64'(bcd14), 64'hDEAD);
        end else begin
          e = q14.pop_front();
          chk("bcd14", 64'(bcd14), 64'(e[43:28]));
          chk("hex14", 64'(hex14), 64'(e[27:0]));
        end
      end
    end
  end

  task automatic wait_done(input int sel);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((sel == 9) ? done9 : done14) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic conv(input int sel, input int value, input bit blank,
                      input logic [15:0] eb, input logic [27:0] eh);
    @(posedge clk); #1;
    if (sel == 9) begin
      val9 = 9'(value); blank9 = blank; start9 = 1'b1; q9.push_back({eb, eh});
    end else begin
      val14 = 14'(value); blank14 = blank; start14 = 1'b1; q14.push_back({eb, eh});
    end
    @(posedge clk); #1;
    start9 = 1'b0; start14 = 1'b0;
    wait_done(sel);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd9",  64'(bcd9),  64'h0);
    chk("rst_hex9",  64'(hex9),  64'hFFFFFFF);
    chk("rst_busy9", 64'(busy9), 64'h0);
    chk("rst_done9", 64'(done9), 64'h0);
    chk("rst_hex14", 64'(hex14), 64'hFFFFFFF);
    rst = 1'b0;

    conv(9, 0,   1'b1, 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    conv(9, 511, 1'b0, 16'h0511, {7'h40, 7'h12, 7'h79, 7'h79});
    conv(9, 511, 1'b1, 16'h0511, {7'h7F, 7'h12, 7'h79, 7'h79});

    // start pulses during SHIFT must be ignored
    @(posedge clk); #1;
    val9 = 9'd37; blank9 = 1'b0; start9 = 1'b1;
    q9.push_back({16'h0037, {7'h40, 7'h40, 7'h30, 7'h78}});
    @(posedge clk); #1;
    start9 = 1'b0; val9 = 9'd100;
    repeat (2) @(posedge clk); #1 start9 = 1'b1;
    @(posedge clk); #1 start9 = 1'b0;
    repeat (2) @(posedge clk); #1 start9 = 1'b1;
    @(posedge clk); #1 start9 = 1'b0;
    wait_done(9);
    repeat (3) @(negedge clk);
    chk("no_extra_busy", 64'(busy9), 64'd0);
    conv(9, 100, 1'b0, 16'h0100, {7'h40, 7'h79, 7'h40, 7'h40});

    // reset in the middle of a conversion
    @(posedge clk); #1;
    val9 = 9'd255; blank9 = 1'b0; start9 = 1'b1;
    @(posedge clk); #1 start9 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_bcd9",  64'(bcd9),  64'h0);
    chk("midrst_hex9",  64'(hex9),  64'hFFFFFFF);
    chk("midrst_busy9", 64'(busy9), 64'h0);
    chk("midrst_done9", 64'(done9), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    conv(9, 255, 1'b0, 16'h0255, {7'h40, 7'h24, 7'h12, 7'h12});

    // wider instance: largest representable value and first overflow
    conv(14, 9999,  1'b0, 16'h9999, {7'h10, 7'h10, 7'h10, 7'h10});
    conv(14, 10000, 1'b0, 16'hFFFF, {7'h3F, 7'h3F, 7'h3F, 7'h3F});

    // continuous start: one conversion every p_WIDTH+1 cycles
    @(posedge clk); #1;
    per_chk = 1'b1; last_done = -1;
    val9 = 9'd0; blank9 = 1'b1; start9 = 1'b1;
    q9.push_back({16'h0000, {7'h7F, 7'h7F, 7'h7F, seg_tbl[0]}});
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      #1 val9 = 9'(k);
      q9.push_back({16'(k), {7'h7F, 7'h7F, 7'h7F, seg_tbl[k]}});
      repeat (10) @(posedge clk);
    end
    #1 start9 = 1'b0;
    wait_done(9);
    per_chk = 1'b0;

    for (int i = 0; i < 40 && (q9.size() != 0 || q14.size() != 0); i++) @(negedge clk);
    if (q9.size() != 0 || q14.size() != 0)
      chk("scoreboard_drained", 64'(q9.size() + q14.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
